// File: rtl/smbus_echo_tracker.sv
// Originator side of the SMBus echo path: holds one event on the outgoing frame
// event field until the minimum hold and the remote echo are satisfied, with a bounded number of retries.
module smbus_echo_tracker #(
  parameter int MIN_FRAMES     = 3,
  parameter int TIMEOUT_FRAMES = 64,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       link_up,
  input  logic       echo_en,
  input  logic       frame_tick,
  input  logic       ev_valid,
  input  logic [3:0] ev_code,
  output logic       ev_ready,
  output logic [3:0] tx_event_o,
  input  logic [3:0] rx_event_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam logic [3:0] EV_IDLE          = 4'h0;
  localparam logic [3:0] EV_START         = 4'h1;
  localparam logic [3:0] EV_STOP          = 4'h2;
  localparam logic [3:0] EV_DATA_0        = 4'h3;
  localparam logic [3:0] EV_DATA_1        = 4'h4;
  localparam logic [3:0] EV_BIT_RCV       = 4'h5;
  localparam logic [3:0] EV_START_ECHO    = 4'h8;
  localparam logic [3:0] EV_STOP_ECHO     = 4'h9;
  localparam logic [3:0] EV_DATA_0_ECHO   = 4'hA;
  localparam logic [3:0] EV_DATA_1_ECHO   = 4'hB;
  localparam logic [3:0] EV_DATA_RCV_ECHO = 4'hC;

  localparam int FW = $clog2(TIMEOUT_FRAMES + 1);
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [FW-1:0] MIN_Q      = FW'(MIN_FRAMES);
  localparam logic [FW-1:0] TO_LAST    = FW'(TIMEOUT_FRAMES - 1);
  localparam logic [FW-1:0] TO_MAX     = FW'(TIMEOUT_FRAMES);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  // Returns the echo code the remote end must reflect, or idle when none is expected.
  function automatic logic [3:0] echo_of(input logic [3:0] code);
    case (code)
      EV_START:   echo_of = EV_START_ECHO;
      EV_STOP:    echo_of = EV_STOP_ECHO;
      EV_DATA_0:  echo_of = EV_DATA_0_ECHO;
      EV_DATA_1:  echo_of = EV_DATA_1_ECHO;
      EV_BIT_RCV: echo_of = EV_DATA_RCV_ECHO;
      default:    echo_of = EV_IDLE;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    ev_q, ev_d;
  logic          need_echo_q, need_echo_d;
  logic [FW-1:0] need_min_q, need_min_d;
  logic [FW-1:0] frame_cnt, frame_d;
  logic [RW-1:0] retry_cnt, retry_d;
  logic          echo_seen, seen_d;
  logic          live_q;
  logic          echo_hit;

  assign busy_o = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    ev_d        = ev_q;
    need_echo_d = need_echo_q;
    need_min_d  = need_min_q;
    frame_d     = frame_cnt;
    retry_d     = retry_cnt;
    seen_d      = echo_seen;
    ev_ready    = 1'b0;
    tx_event_o  = EV_IDLE;
    done_o      = 1'b0;
    err_o       = 1'b0;
    echo_hit    = need_echo_q && (rx_event_i == echo_of(ev_q));

    case (state_q)
      ST_IDLE: begin
        ev_ready = link_up & live_q;
        if (ev_valid && ev_ready) begin
          ev_d        = ev_code;
          need_echo_d = echo_en && (echo_of(ev_code) != EV_IDLE);
          need_min_d  = (ev_code == EV_DATA_0 || ev_code == EV_DATA_1 ||
                         ev_code == EV_BIT_RCV) ? MIN_Q : FW'(1);
          frame_d     = '0;
          retry_d     = '0;
          seen_d      = 1'b0;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_event_o = ev_q;
        if (echo_hit) seen_d = 1'b1;
        if (frame_tick && frame_cnt != TO_MAX) frame_d = frame_cnt + 1'b1;
        if (frame_cnt >= need_min_q && (!need_echo_q || echo_seen)) begin
          done_o  = 1'b1;
          state_d = ST_GAP;
        end else if (need_echo_q && !echo_seen && !echo_hit && frame_tick &&
                     frame_cnt == TO_LAST) begin
          // Echo arriving on the timeout tick takes precedence over the retry.
          if (retry_cnt == RETRY_LAST) begin
            err_o   = 1'b1;
            state_d = ST_GAP;
          end else begin
            retry_d = retry_cnt + 1'b1;
            frame_d = '0;
          end
        end
      end
      ST_GAP: begin
        if (frame_tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!link_up) begin
      state_d = ST_IDLE;
      ev_d    = EV_IDLE;
      done_o  = 1'b0;
      err_o   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ev_q        <= EV_IDLE;
      need_echo_q <= 1'b0;
      need_min_q  <= '0;
      frame_cnt   <= '0;
      retry_cnt   <= '0;
      echo_seen   <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ev_q        <= ev_d;
      need_echo_q <= need_echo_d;
      need_min_q  <= need_min_d;
      frame_cnt   <= frame_d;
      retry_cnt   <= retry_d;
      echo_seen   <= seen_d;
      live_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_smbus_echo_tracker.sv
// Scoreboard bench for smbus_echo_tracker: expected completions are queued at accept
// and matched by a monitor against done_o/err_o/abort, hold ticks and the idle gap.
module tb_smbus_echo_tracker;

  localparam logic [3:0] EV_IDLE          = 4'h0;
  localparam logic [3:0] EV_START         = 4'h1;
  localparam logic [3:0] EV_STOP          = 4'h2;
  localparam logic [3:0] EV_DATA_0        = 4'h3;
  localparam logic [3:0] EV_DATA_1        = 4'h4;
  localparam logic [3:0] EV_BIT_RCV       = 4'h5;
  localparam logic [3:0] EV_START_RCV     = 4'h6;
  localparam logic [3:0] EV_START_ECHO    = 4'h8;
  localparam logic [3:0] EV_STOP_ECHO     = 4'h9;
  localparam logic [3:0] EV_DATA_0_ECHO   = 4'hA;
  localparam logic [3:0] EV_DATA_1_ECHO   = 4'hB;
  localparam logic [3:0] EV_DATA_RCV_ECHO = 4'hC;
  localparam logic [3:0] EV_RSVD          = 4'hE;

  localparam int RES_DONE  = 0;
  localparam int RES_ERR   = 1;
  localparam int RES_ABORT = 2;

  typedef struct {
    logic [3:0] code;
    int         hold;
    int         res;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       link_up;
  logic       echo_en;
  logic       frame_tick;
  logic       ev_valid;
  logic [3:0] ev_code;
  logic       ev_ready;
  logic [3:0] tx_event_o;
  logic [3:0] rx_event_i;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  smbus_echo_tracker #(.MIN_FRAMES(3), .TIMEOUT_FRAMES(8), .MAX_RETRY(3)) dut (
    .clk(clk), .reset_n(reset_n), .link_up(link_up), .echo_en(echo_en),
    .frame_tick(frame_tick), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_ready(ev_ready), .tx_event_o(tx_event_o), .rx_event_i(rx_event_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] echo_for(input logic [3:0] code);
    case (code)
      EV_START:   return EV_START_ECHO;
      EV_STOP:    return EV_STOP_ECHO;
      EV_DATA_0:  return EV_DATA_0_ECHO;
      EV_DATA_1:  return EV_DATA_1_ECHO;
      EV_BIT_RCV: return EV_DATA_RCV_ECHO;
      default:    return EV_IDLE;
    endcase
  endfunction

  // Monitor: tracks each non-idle burst on tx_event_o and resolves it against the queue.
  bit   active = 0;
  bit   flagged = 0;
  bit   busy_prev = 0;
  int   hold = 0;
  int   gap = 0;
  int   exp_gap = 0;
  logic [3:0] cur_code = EV_IDLE;

  task automatic resolve(input int res, input logic [3:0] code);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_completion", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("result", res, e.res);
      check("event_code", code, e.code);
      check("hold_ticks", hold, e.hold);
    end
    exp_gap = (res == RES_ABORT) ? 0 : 1;
    gap = 0;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      active = 0;
      busy_prev = 0;
    end else begin
      if (tx_event_o != EV_IDLE) begin
        if (!active) begin
          active = 1; flagged = 0; hold = 0; gap = 0; cur_code = tx_event_o;
        end
        if (frame_tick) hold++;
      end
      if (done_o || err_o) begin
        check("done_err_exclusive", {31'd0, done_o & err_o}, 0);
        check("single_pulse", {31'd0, flagged}, 0);
        resolve(err_o ? RES_ERR : RES_DONE, tx_event_o);
        flagged = 1;
      end
      if (active && tx_event_o == EV_IDLE) begin
        active = 0;
        if (!flagged) resolve(RES_ABORT, cur_code);
      end
      if (busy_o && !active && tx_event_o == EV_IDLE && frame_tick) gap++;
      if (busy_prev && !busy_o) check("gap_ticks", gap, exp_gap);
      busy_prev = busy_o;
    end
  end

  task automatic run_event(input logic [3:0] code, input logic en, input int echo_tick,
                           input int drop_tick, input int exp_hold, input int exp_res,
                           input bit flip_en);
    bit accepted = 0;
    bit finished = 0;
    bit drop_pending = 0;
    int tick_n = 0;
    echo_en  = en;
    ev_code  = code;
    ev_valid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (ev_ready) begin
        check("tx_idle_before_accept", tx_event_o, EV_IDLE);
        exp_q.push_back('{code, exp_hold, exp_res});
        accepted = 1;
      end
    end
    if (!accepted) begin
      check("accept_timeout", 0, 1);
      ev_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ev_valid = 1'b0;
    if (flip_en) echo_en = !en;
    @(negedge clk);
    check("tx_after_accept", tx_event_o, code);
    for (int c = 0; c < 400 && !finished; c++) begin
      @(posedge clk); #1;
      if (drop_pending) begin
        link_up = 1'b0;
        drop_pending = 0;
      end
      frame_tick = (c % 4 == 3);
      rx_event_i = EV_IDLE;
      if (frame_tick) begin
        tick_n++;
        if (tick_n == echo_tick) rx_event_i = echo_for(code);
        if (tick_n == drop_tick) drop_pending = 1;
      end
      @(negedge clk);
      if (!busy_o) finished = 1;
    end
    if (!finished) check("event_timeout", 0, 1);
    @(posedge clk); #1;
    frame_tick = 1'b0;
    rx_event_i = EV_IDLE;
    if (!link_up) begin
      @(negedge clk);
      check("ready_while_link_down", {31'd0, ev_ready}, 0);
      @(posedge clk); #1;
      link_up = 1'b1;
    end
  endtask

  initial begin
    reset_n = 1'b0; link_up = 1'b1; echo_en = 1'b1; frame_tick = 1'b0;
    ev_valid = 1'b1; ev_code = EV_START; rx_event_i = EV_IDLE;
    repeat (3) @(negedge clk);
    check("rst_ev_ready", {31'd0, ev_ready}, 0);
    check("rst_tx_event", tx_event_o, EV_IDLE);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_done", {31'd0, done_o}, 0);
    check("rst_err", {31'd0, err_o}, 0);
    link_up = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("link_down_ev_ready", {31'd0, ev_ready}, 0);
    check("link_down_busy", {31'd0, busy_o}, 0);
    @(posedge clk); #1;
    link_up = 1'b1;

    //        code          en  echo drop hold res        flip
    run_event(EV_START,     1,  1,   0,   1,   RES_DONE,  0);
    run_event(EV_DATA_0,    1,  1,   0,   3,   RES_DONE,  0);
    run_event(EV_BIT_RCV,   1,  0,   0,   24,  RES_ERR,   0);
    run_event(EV_STOP,      1,  10,  0,   10,  RES_DONE,  0);
    run_event(EV_DATA_1,    1,  2,   0,   3,   RES_DONE,  0);
    run_event(EV_DATA_1,    1,  2,   0,   3,   RES_DONE,  0);
    run_event(EV_DATA_0,    1,  0,   2,   2,   RES_ABORT, 0);
    run_event(EV_START,     1,  8,   0,   8,   RES_DONE,  0);
    run_event(EV_START,     0,  0,   0,   1,   RES_DONE,  1);
    run_event(EV_START_RCV, 1,  0,   0,   1,   RES_DONE,  0);
    run_event(EV_RSVD,      1,  0,   0,   1,   RES_DONE,  0);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
